// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/operand/status bundle between the multiply sequencer and its user.
interface mul_seq_ctrl_if #(parameter int WIDTH = 16, parameter int CNT_W = 5);
  logic start;
  logic [WIDTH-1:0] md_in;
  logic [WIDTH-1:0] mr_in;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  logic mr_load;
  logic step_add;
  logic [CNT_W-1:0] step_cnt;
  logic mr_flag;
  modport master(output start, md_in, mr_in, input busy, done, product, mr_load, step_add, step_cnt, mr_flag);
  modport slave(input start, md_in, mr_in, output busy, done, product, mr_load, step_add, step_cnt, mr_flag);
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-add multiply sequencer, state on the falling clock edge.
// Define SIGNED_MUL_EN for radix-2 Booth (two's-complement) instead of unsigned shift-add.
module mul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  mul_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] acc, sum, acc_nx;
  logic [WIDTH-1:0] mr, md, mr_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] prod;
  logic add;
`ifdef SIGNED_MUL_EN
  logic q1;
  logic [WIDTH:0] mde;
  always_comb begin
    mde = {md[WIDTH-1], md};
    add = mr[0] ^ q1;
    sum = ({mr[0], q1} == 2'b10) ? acc - mde : ({mr[0], q1} == 2'b01) ? acc + mde : acc;
    acc_nx = {sum[WIDTH], sum[WIDTH:1]};
    mr_nx = {sum[0], mr[WIDTH-1:1]};
  end
  always_ff @(negedge clk or posedge rst)
    if (rst) q1 <= 1'b0;
    else if (state == LOAD) q1 <= 1'b0;
    else if (state == STEP) q1 <= mr[0];
`else
  always_comb begin
    add = mr[0];
    sum = add ? acc + {1'b0, md} : acc;
    acc_nx = {1'b0, sum[WIDTH:1]};
    mr_nx = {sum[0], mr[WIDTH-1:1]};
  end
`endif
  always_ff @(negedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (bus.start ? LOAD : IDLE) :
               (state == LOAD) ? STEP :
               (state == STEP) ? ((cnt == CNT_W'(WIDTH-1)) ? DONE : STEP) : IDLE;
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.mr_load = state == LOAD;
    bus.step_add = (state == STEP) && add;
    bus.step_cnt = cnt;
    bus.mr_flag = ~mr[WIDTH-1];
    bus.product = prod;
  end
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      mr <= '0;
      md <= '0;
      cnt <= '0;
      prod <= '0;
    end else if (state == LOAD) begin
      acc <= '0;
      mr <= bus.mr_in;
      md <= bus.md_in;
      cnt <= '0;
    end else if (state == STEP) begin
      acc <= acc_nx;
      mr <= mr_nx;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH-1)) prod <= {acc_nx[WIDTH-1:0], mr_nx};
    end
endmodule
